// File: rtl/alu_control_unit_pkg.sv
// Shared types, opcode map and instruction field positions for the
// accumulator ALU control unit and its decoder.
package alu_control_unit_pkg;

   localparam int INSTR_W = 16;
   localparam int DATA_W  = 8;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int SRC_BIT = 11;
   localparam int REG_MSB = 9;
   localparam int REG_LSB = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_NOT = 3'b101,
      ALU_LD  = 3'b110
   } alu_op_t;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOT   = 4'h5,
      OP_LD    = 4'h6,
      OP_LDI   = 4'h7,
      OP_ST    = 4'h8,
      OP_JMP   = 4'h9,
      OP_JZ    = 4'hA,
      OP_NOP   = 4'hB,
      OP_RSV_C = 4'hC,
      OP_RSV_D = 4'hD,
      OP_RSV_E = 4'hE,
      OP_HALT  = 4'hF
   } instr_op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM,
      S_EXEC,
      S_HALT
   } cu_state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LDI,
      CLS_ST,
      CLS_JMP,
      CLS_JZ,
      CLS_NOP,
      CLS_HALT,
      CLS_ILL
   } op_class_t;

   // Opcodes 0x0-0x6 map one-to-one onto the ALU operation encoding.
   function automatic logic is_alu_op(input instr_op_t op);
      return (op <= OP_LD);
   endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// Control-unit side bus: program memory, data memory, accumulator feedback
// and datapath strobes. master = control unit, slave = datapath/memories.
interface alu_control_unit_if
   import alu_control_unit_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int DM_AW = 8
);
   logic                 start;
   logic [INSTR_W-1:0]   pm_data;
   logic [DATA_W-1:0]    acumulator;

   logic [PC_W-1:0]      pm_addr;
   logic                 pm_rd;
   logic [DM_AW-1:0]     dm_addr;
   logic                 dm_rd;
   logic [2:0]           operation_code;
   logic                 acumulator_ce;
   logic                 direct_load;
   logic [DATA_W-1:0]    direct_data;
   logic [2:0]           register_file_ce;
   logic [1:0]           register_file_mux_addr;
   logic                 data_memory_read_enable;
   logic                 busy;
   logic                 halted;
   logic                 illegal;

   modport master (
      input  start, pm_data, acumulator,
      output pm_addr, pm_rd, dm_addr, dm_rd, operation_code, acumulator_ce,
             direct_load, direct_data, register_file_ce, register_file_mux_addr,
             data_memory_read_enable, busy, halted, illegal
   );

   modport slave (
      output start, pm_data, acumulator,
      input  pm_addr, pm_rd, dm_addr, dm_rd, operation_code, acumulator_ce,
             direct_load, direct_data, register_file_ce, register_file_mux_addr,
             data_memory_read_enable, busy, halted, illegal
   );

endinterface

// File: rtl/alu_control_unit_decoder.sv
// Combinational instruction decoder: splits a 16-bit instruction into its
// operation class, ALU op, operand source, register address and immediate.
module alu_instr_decoder
   import alu_control_unit_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output op_class_t          op_class,
   output alu_op_t            alu_op,
   output logic               src_dm,
   output logic [1:0]         reg_addr,
   output logic [DATA_W-1:0]  imm,
   output logic               illegal
);

   instr_op_t opcode;
   logic      unused_bit10;

   assign opcode       = instr_op_t'(instr[OPC_MSB:OPC_LSB]);
   assign src_dm       = instr[SRC_BIT];
   assign reg_addr     = instr[REG_MSB:REG_LSB];
   assign imm          = instr[IMM_MSB:IMM_LSB];
   assign unused_bit10 = instr[SRC_BIT-1];

   always_comb begin
      op_class = CLS_ILL;
      alu_op   = ALU_ADD;
      illegal  = 1'b0;
      if (is_alu_op(opcode)) begin
         op_class = CLS_ALU;
         alu_op   = alu_op_t'(instr[OPC_LSB+2:OPC_LSB]);
      end else begin
         case (opcode)
            OP_LDI:  op_class = CLS_LDI;
            // r0 is not a writable register, so ST r0 is rejected
            OP_ST: begin
               op_class = CLS_ST;
               illegal  = (reg_addr == 2'b00);
            end
            OP_JMP:  op_class = CLS_JMP;
            OP_JZ:   op_class = CLS_JZ;
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: begin
               op_class = CLS_ILL;
               illegal  = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator ALU.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | after reset, waits for start
//   S_FETCH  | program memory read at PC
//   S_DECODE | instruction word arrives and is latched
//   S_MEM    | data memory read for a DM-sourced ALU op
//   S_EXEC   | one-cycle datapath strobes, PC update
//   S_HALT   | stopped, start restarts from PC 0
module alu_control_unit
   import alu_control_unit_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int DM_AW = 8
) (
   input  logic               clk_sys,
   input  logic               rst_b,
   alu_control_unit_if.master bus
);

   cu_state_t          state;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;

   logic [INSTR_W-1:0] dec_instr;
   op_class_t          dec_class;
   alu_op_t            dec_alu_op;
   logic               dec_src_dm;
   logic [1:0]         dec_reg;
   logic [DATA_W-1:0]  dec_imm;
   logic               dec_illegal;

   logic               need_mem;
   logic               enter_exec;
   logic [PC_W-1:0]    pc_next;

   alu_op_t            exec_op;
   logic               exec_acc_ce;
   logic               exec_direct_load;
   logic [DATA_W-1:0]  exec_direct_data;
   logic [2:0]         exec_rf_ce;
   logic [1:0]         exec_mux;
   logic               exec_dm_sel;

   // Outputs are registered from the next state, so DECODE must look at the
   // word arriving from program memory rather than the stale IR.
   assign dec_instr = (state == S_DECODE) ? bus.pm_data : ir;

   alu_instr_decoder u_decoder (
      .instr    (dec_instr),
      .op_class (dec_class),
      .alu_op   (dec_alu_op),
      .src_dm   (dec_src_dm),
      .reg_addr (dec_reg),
      .imm      (dec_imm),
      .illegal  (dec_illegal)
   );

   assign need_mem   = (dec_class == CLS_ALU) && dec_src_dm;
   assign enter_exec = ((state == S_DECODE) && !need_mem) || (state == S_MEM);
   assign bus.pm_addr = pc;

   always_comb begin
      exec_op          = ALU_ADD;
      exec_acc_ce      = 1'b0;
      exec_direct_load = 1'b0;
      exec_direct_data = '0;
      exec_rf_ce       = 3'b000;
      exec_mux         = 2'b00;
      exec_dm_sel      = 1'b0;
      case (dec_class)
         CLS_ALU: begin
            exec_op     = dec_alu_op;
            exec_acc_ce = 1'b1;
            exec_mux    = dec_reg;
            exec_dm_sel = dec_src_dm;
         end
         CLS_LDI: begin
            exec_acc_ce      = 1'b1;
            exec_direct_load = 1'b1;
            exec_direct_data = dec_imm;
         end
         CLS_ST: begin
            if (!dec_illegal) exec_rf_ce = {1'b0, dec_reg};
         end
         default: ;
      endcase
   end

   always_comb begin
      pc_next = pc + 1'b1;
      if ((dec_class == CLS_JMP) || ((dec_class == CLS_JZ) && (bus.acumulator == '0)))
         pc_next = PC_W'(dec_imm);
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         state                        <= S_IDLE;
         pc                           <= '0;
         ir                           <= '0;
         bus.pm_rd                    <= 1'b0;
         bus.dm_rd                    <= 1'b0;
         bus.dm_addr                  <= '0;
         bus.operation_code           <= 3'b000;
         bus.acumulator_ce            <= 1'b0;
         bus.direct_load              <= 1'b0;
         bus.direct_data              <= '0;
         bus.register_file_ce         <= 3'b000;
         bus.register_file_mux_addr   <= 2'b00;
         bus.data_memory_read_enable  <= 1'b0;
         bus.busy                     <= 1'b0;
         bus.halted                   <= 1'b0;
         bus.illegal                  <= 1'b0;
      end else begin
         bus.pm_rd                    <= 1'b0;
         bus.dm_rd                    <= 1'b0;
         bus.dm_addr                  <= '0;
         bus.operation_code           <= 3'b000;
         bus.acumulator_ce            <= 1'b0;
         bus.direct_load              <= 1'b0;
         bus.direct_data              <= '0;
         bus.register_file_ce         <= 3'b000;
         bus.register_file_mux_addr   <= 2'b00;
         bus.data_memory_read_enable  <= 1'b0;
         bus.busy                     <= 1'b0;
         bus.halted                   <= 1'b0;
         bus.illegal                  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state     <= S_FETCH;
                  bus.pm_rd <= 1'b1;
                  bus.busy  <= 1'b1;
               end
            end
            S_FETCH: begin
               state    <= S_DECODE;
               bus.busy <= 1'b1;
            end
            S_DECODE: begin
               ir       <= bus.pm_data;
               bus.busy <= 1'b1;
               if (need_mem) begin
                  state       <= S_MEM;
                  bus.dm_rd   <= 1'b1;
                  bus.dm_addr <= DM_AW'(dec_imm);
               end else begin
                  state <= S_EXEC;
               end
            end
            S_MEM: begin
               state    <= S_EXEC;
               bus.busy <= 1'b1;
            end
            S_EXEC: begin
               if (dec_class == CLS_HALT) begin
                  state      <= S_HALT;
                  bus.halted <= 1'b1;
               end else begin
                  state     <= S_FETCH;
                  pc        <= pc_next;
                  bus.pm_rd <= 1'b1;
                  bus.busy  <= 1'b1;
               end
            end
            S_HALT: begin
               if (bus.start) begin
                  state     <= S_FETCH;
                  pc        <= '0;
                  bus.pm_rd <= 1'b1;
                  bus.busy  <= 1'b1;
               end else begin
                  bus.halted <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (enter_exec) begin
            bus.operation_code          <= exec_op;
            bus.acumulator_ce           <= exec_acc_ce;
            bus.direct_load             <= exec_direct_load;
            bus.direct_data             <= exec_direct_data;
            bus.register_file_ce        <= exec_rf_ce;
            bus.register_file_mux_addr  <= exec_mux;
            bus.data_memory_read_enable <= exec_dm_sel;
            bus.illegal                 <= dec_illegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: a program memory model, a
// scoreboard of expected EXEC-cycle outputs and a phase-tracking monitor.
module tb_alu_control_unit;
   import alu_control_unit_pkg::*;

   logic clk_sys = 1'b0;
   logic rst_b;

   always #5 clk_sys = ~clk_sys;

   alu_control_unit_if bus ();

   alu_control_unit u_dut (
      .clk_sys (clk_sys),
      .rst_b   (rst_b),
      .bus     (bus)
   );

   typedef struct packed {
      logic [7:0] pm_addr;
      logic       pm_rd;
      logic [7:0] dm_addr;
      logic       dm_rd;
      logic [2:0] op;
      logic       ce;
      logic       dl;
      logic [7:0] dd;
      logic [2:0] rfce;
      logic [1:0] mux;
      logic       dmre;
      logic       busy;
      logic       halted;
      logic       ill;
   } out_t;

   typedef struct packed {
      out_t       o;
      logic       mem;
      logic [7:0] mem_addr;
   } rec_t;

   logic [15:0] prog [256];
   rec_t        sb [$];
   rec_t        obs;
   rec_t        exp_r;
   int          phase = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   // synchronous program memory: data one cycle after the read strobe
   always @(posedge clk_sys) if (bus.pm_rd) bus.pm_data <= prog[bus.pm_addr];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic out_t sample_outs();
      out_t s;
      s.pm_addr = bus.pm_addr;
      s.pm_rd   = bus.pm_rd;
      s.dm_addr = bus.dm_addr;
      s.dm_rd   = bus.dm_rd;
      s.op      = bus.operation_code;
      s.ce      = bus.acumulator_ce;
      s.dl      = bus.direct_load;
      s.dd      = bus.direct_data;
      s.rfce    = bus.register_file_ce;
      s.mux     = bus.register_file_mux_addr;
      s.dmre    = bus.data_memory_read_enable;
      s.busy    = bus.busy;
      s.halted  = bus.halted;
      s.ill     = bus.illegal;
      return s;
   endfunction

   function automatic rec_t model(input logic [7:0] pc, input logic [15:0] ins);
      rec_t       r;
      logic [3:0] opc;
      r         = '0;
      opc       = ins[15:12];
      r.o.pm_addr = pc;
      r.o.busy    = 1'b1;
      if (opc <= 4'h6) begin
         r.o.op   = opc[2:0];
         r.o.ce   = 1'b1;
         r.o.mux  = ins[9:8];
         r.o.dmre = ins[11];
         r.mem    = ins[11];
         if (ins[11]) r.mem_addr = ins[7:0];
      end else if (opc == 4'h7) begin
         r.o.ce = 1'b1;
         r.o.dl = 1'b1;
         r.o.dd = ins[7:0];
      end else if (opc == 4'h8) begin
         if (ins[9:8] == 2'b00) r.o.ill = 1'b1;
         else r.o.rfce = {1'b0, ins[9:8]};
      end else if (opc inside {4'hC, 4'hD, 4'hE}) begin
         r.o.ill = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [7:0] next_pc(input logic [7:0] pc, input logic [15:0] ins,
                                          input logic [7:0] acc);
      logic [3:0] opc;
      opc = ins[15:12];
      if (opc == 4'h9) return ins[7:0];
      if ((opc == 4'hA) && (acc == 8'h00)) return ins[7:0];
      return pc + 8'h01;
   endfunction

   // Monitor: FETCH (pm_rd) -> DECODE -> optional MEM (dm_rd) -> EXEC.
   always @(negedge clk_sys) begin
      if (!rst_b) begin
         phase = 0;
      end else begin
         case (phase)
            0: if (bus.pm_rd) phase = 1;
            1: begin
               obs   = '0;
               phase = 2;
            end
            default: begin
               if ((phase == 2) && bus.dm_rd) begin
                  obs.mem      = 1'b1;
                  obs.mem_addr = bus.dm_addr;
                  phase        = 3;
               end else begin
                  obs.o = sample_outs();
                  if (sb.size() == 0) begin
                     chk("sb_underflow", 64'(sb.size()), 64'd1);
                  end else begin
                     exp_r = sb.pop_front();
                     chk($sformatf("exec_pc%02h", exp_r.o.pm_addr), 64'(obs), 64'(exp_r));
                  end
                  phase = 0;
               end
            end
         endcase
      end
   end

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
   endtask

   task automatic plan(input int steps);
      logic [7:0]  pc;
      logic [15:0] ins;
      pc = 8'h00;
      for (int i = 0; i < steps; i++) begin
         ins = prog[pc];
         sb.push_back(model(pc, ins));
         if (ins[15:12] == 4'hF) break;
         pc = next_pc(pc, ins, bus.acumulator);
      end
   endtask

   // start is held for three cycles to show it is ignored while busy
   task automatic run(input bit until_halt, input int budget, input int exp_cyc);
      int cyc;
      bit done;
      cyc  = 0;
      done = 1'b0;
      @(negedge clk_sys);
      bus.start = 1'b1;
      while (!done && (cyc < budget)) begin
         @(posedge clk_sys);
         #1;
         cyc++;
         if (cyc == 1) chk("fetch_pc0", 64'({bus.pm_rd, bus.pm_addr}), 64'({1'b1, 8'h00}));
         if (cyc == 3) bus.start = 1'b0;
         done = until_halt ? bus.halted : (sb.size() == 0);
      end
      bus.start = 1'b0;
      chk("run_done", 64'(done), 64'd1);
      if (exp_cyc > 0) chk("latency", 64'(cyc), 64'(exp_cyc));
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk_sys);
      #1;
      rst_b = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      out_t e;
      int   cyc;
      rst_b          = 1'b0;
      bus.start      = 1'b0;
      bus.acumulator = 8'h00;
      clear_prog();
      repeat (2) @(posedge clk_sys);
      #1;
      chk("reset_outs", 64'(sample_outs()), 64'd0);
      @(negedge clk_sys);
      rst_b = 1'b1;

      // reset landing in the EXEC cycle of an ADD
      prog[0] = 16'h0100;
      plan(1);
      @(negedge clk_sys);
      bus.start = 1'b1;
      cyc = 0;
      while ((cyc < 10) && !bus.acumulator_ce) begin
         @(posedge clk_sys);
         #1;
         cyc++;
         bus.start = 1'b0;
      end
      chk("mid_exec_seen", 64'(bus.acumulator_ce), 64'd1);
      @(negedge clk_sys);
      #1;
      rst_b = 1'b0;
      @(posedge clk_sys);
      #1;
      chk("reset_mid_exec", 64'(sample_outs()), 64'd0);
      @(negedge clk_sys);
      rst_b = 1'b1;
      repeat (3) begin
         @(posedge clk_sys);
         #1;
         chk("idle_after_reset", 64'(sample_outs()), 64'd0);
      end

      // LDI 0x05; ADD r1; HALT
      clear_prog();
      prog[0] = 16'h7005;
      prog[1] = 16'h0100;
      plan(8);
      run(1'b1, 40, 10);

      // XOR DM[0x20]; SUB DM[0x33] with bit 10 set; NOT r3; LD r2; HALT
      clear_prog();
      prog[0] = 16'h4820;
      prog[1] = 16'h1C33;
      prog[2] = 16'h5300;
      prog[3] = 16'h6200;
      plan(8);
      run(1'b1, 60, 18);

      // ST r2; ST r0; opcode 0xD; NOP; HALT at 0x04, then hold in HALT
      clear_prog();
      prog[0] = 16'h8200;
      prog[1] = 16'h8000;
      prog[2] = 16'hD000;
      prog[3] = 16'hB000;
      plan(8);
      run(1'b1, 60, 16);
      e         = '0;
      e.pm_addr = 8'h04;
      e.halted  = 1'b1;
      repeat (10) begin
         @(posedge clk_sys);
         #1;
         chk("halt_hold", 64'(sample_outs()), 64'(e));
      end

      // JZ 0x10 taken and not taken
      clear_prog();
      prog[0] = 16'hA010;
      bus.acumulator = 8'h00;
      plan(8);
      run(1'b1, 40, 7);
      bus.acumulator = 8'h01;
      plan(8);
      run(1'b1, 40, 7);
      bus.acumulator = 8'h00;

      // NOP at 0xFF wraps to 0x00
      clear_prog();
      prog[0]     = 16'h9FFF;
      prog[8'hFF] = 16'hB000;
      plan(5);
      run(1'b0, 60, 0);
      do_reset();

      // JMP from 0xFF to 0x00
      clear_prog();
      prog[0]     = 16'h90FE;
      prog[8'hFE] = 16'hB000;
      prog[8'hFF] = 16'h9000;
      plan(6);
      run(1'b0, 60, 0);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
